stopwatch_btn_ctrl: RTL and testbench



---
 rtl/stopwatch_btn_ctrl_if.sv | 41 ++++
 rtl/stopwatch_btn_ctrl.sv | 131 +++++++++++++
 tb/tb_stopwatch_btn_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/stopwatch_btn_ctrl_if.sv
// rtl/stopwatch_btn_ctrl_if.sv - button/datapath signal bundle for the stopwatch control FSM
//
// Purpose: groups the two debounced button levels and the counter/display
// control outputs of stopwatch_btn_ctrl.
// Signals:
//   pb_ss     start/stop button level, active high
//   pb_lr     lap/reset button level, active high
//   count_en  time counter advances when 1
//   disp_hold display frozen at lap value when 1
//   clr       one-cycle pulse zeroing the time counter
//   state     FSM state: IDLE=00, RUN=01, LAP=10, STOP=11
// Modports:
//   master  environment side (drives buttons, observes controls)
//   slave   controller side (samples buttons, drives controls)

interface stopwatch_btn_ctrl_if;
    logic       pb_ss;
    logic       pb_lr;
    logic       count_en;
    logic       disp_hold;
    logic       clr;
    logic [1:0] state;

    modport master (
        output pb_ss,
        output pb_lr,
        input  count_en,
        input  disp_hold,
        input  clr,
        input  state
    );

    modport slave (
        input  pb_ss,
        input  pb_lr,
        output count_en,
        output disp_hold,
        output clr,
        output state
    );
endinterface

// File: rtl/stopwatch_btn_ctrl.sv
// rtl/stopwatch_btn_ctrl.sv - stopwatch button control FSM with lap/reset long-press detection
//
// Purpose: turns debounced start/stop and lap/reset levels into edge events,
// times long presses of lap/reset, and sequences IDLE/RUN/LAP/STOP, driving
// count enable, display freeze and a one-cycle counter clear.
// Ports:
//   clk_d  slow system clock (same as the debouncers)
//   rst_n  asynchronous active-low reset
//   bus    stopwatch_btn_ctrl_if.slave: pb_ss, pb_lr in; count_en,
//          disp_hold, clr, state out (all outputs registered)
// Parameters:
//   LONG_CYC  consecutive high samples of pb_lr that make a long press (2..255)
//   HW        hold counter width, 2**HW > LONG_CYC

module stopwatch_btn_ctrl #(
    parameter int LONG_CYC = 200,
    parameter int HW       = 8
) (
    input  logic                 clk_d,
    input  logic                 rst_n,
    stopwatch_btn_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    state_t        state_q, state_d;
    logic          ss_q, lr_q;
    logic          armed, armed_d;
    logic [HW-1:0] hold_cnt, hold_cnt_d;
    logic          count_en_q, disp_hold_q, clr_q;
    logic          clr_ev;

    logic ss_rise, lr_rise, lr_fall;
    logic long_ev, short_ev;

    assign ss_rise  = bus.pb_ss & ~ss_q;
    assign lr_rise  = bus.pb_lr & ~lr_q;
    assign lr_fall  = ~bus.pb_lr & lr_q;

    // The rise cycle counts as the first high sample, so the terminal compare
    // is against LONG_CYC-1 rather than LONG_CYC.
    assign long_ev  = armed & bus.pb_lr & (hold_cnt == HOLD_LAST);
    assign short_ev = armed & lr_fall;

    always_comb begin
        state_d    = state_q;
        armed_d    = armed;
        hold_cnt_d = hold_cnt;
        clr_ev     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_rise) begin
                    state_d = RUN;
                end
            end
            RUN, LAP: begin
                if (ss_rise) begin
                    state_d    = STOP;
                    armed_d    = 1'b0;
                    hold_cnt_d = '0;
                end else if (long_ev) begin
                    state_d    = IDLE;
                    clr_ev     = 1'b1;
                    armed_d    = 1'b0;
                    hold_cnt_d = '0;
                end else if (short_ev) begin
                    state_d    = (state_q == RUN) ? LAP : RUN;
                    armed_d    = 1'b0;
                    hold_cnt_d = '0;
                end else if (lr_rise) begin
                    armed_d    = 1'b1;
                    hold_cnt_d = HOLD_ONE;
                end else if (armed && bus.pb_lr) begin
                    hold_cnt_d = hold_cnt + HOLD_ONE;
                end
            end
            STOP: begin
                if (ss_rise) begin
                    state_d = RUN;
                end else if (lr_rise) begin
                    state_d = IDLE;
                    clr_ev  = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                armed_d    = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Previous-level regs reset high so a button held through reset release
    // produces no edge.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_q        <= 1'b1;
            lr_q        <= 1'b1;
            armed       <= 1'b0;
            hold_cnt    <= '0;
            count_en_q  <= 1'b0;
            disp_hold_q <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_q        <= bus.pb_ss;
            lr_q        <= bus.pb_lr;
            armed       <= armed_d;
            hold_cnt    <= hold_cnt_d;
            count_en_q  <= (state_d == RUN) || (state_d == LAP);
            disp_hold_q <= (state_d == LAP);
            clr_q       <= clr_ev;
        end
    end

    assign bus.count_en  = count_en_q;
    assign bus.disp_hold = disp_hold_q;
    assign bus.clr       = clr_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// tb/tb_stopwatch_btn_ctrl.sv - directed self-checking bench for stopwatch_btn_ctrl
//
// Purpose: drives button sequences into stopwatch_btn_ctrl (LONG_CYC=4) and
// compares {count_en, disp_hold, clr, state} against hand-computed values.
// Ports: none (top-level bench).

module tb_stopwatch_btn_ctrl;

    logic clk_d;
    logic rst_n;
    int   total;
    int   bad;

    localparam logic [4:0] O_IDLE = 5'b000_00;
    localparam logic [4:0] O_CLR  = 5'b001_00;
    localparam logic [4:0] O_RUN  = 5'b100_01;
    localparam logic [4:0] O_LAP  = 5'b110_10;
    localparam logic [4:0] O_STOP = 5'b000_11;

    stopwatch_btn_ctrl_if bus ();

    stopwatch_btn_ctrl #(
        .LONG_CYC (4),
        .HW       (8)
    ) dut (
        .clk_d (clk_d),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk_d = 1'b0;
    always #5 clk_d = ~clk_d;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.count_en, bus.disp_hold, bus.clr, bus.state};
    endfunction

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        bus.pb_ss = 1'b1;
        bus.pb_lr = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset_outs", {3'b0, outs()}, {3'b0, O_IDLE});
        rst_n = 1'b0;
        #1 rst_n = 1'b1;

        // Buttons held through reset release must not create edges.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_idle", {3'b0, outs()}, {3'b0, O_IDLE});
        end

        bus.pb_ss = 1'b0; bus.pb_lr = 1'b0; tick();
        check("release_idle", {3'b0, outs()}, {3'b0, O_IDLE});

        // IDLE -> RUN -> STOP -> IDLE with single clr pulse
        bus.pb_ss = 1'b1; tick();
        check("idle_to_run", {3'b0, outs()}, {3'b0, O_RUN});
        bus.pb_ss = 1'b0; tick();
        check("run_stay", {3'b0, outs()}, {3'b0, O_RUN});
        bus.pb_ss = 1'b1; tick();
        check("run_to_stop", {3'b0, outs()}, {3'b0, O_STOP});
        bus.pb_ss = 1'b0; tick();
        check("stop_stay", {3'b0, outs()}, {3'b0, O_STOP});
        bus.pb_lr = 1'b1; tick();
        check("stop_clr", {3'b0, outs()}, {3'b0, O_CLR});
        tick();
        check("clr_one_cycle", {3'b0, outs()}, {3'b0, O_IDLE});
        bus.pb_lr = 1'b0; tick();
        check("idle_lr_fall", {3'b0, outs()}, {3'b0, O_IDLE});

        // Short press of 3 high samples in RUN -> LAP, then LAP -> RUN
        bus.pb_ss = 1'b1; tick();
        bus.pb_ss = 1'b0; tick();
        check("run_again", {3'b0, outs()}, {3'b0, O_RUN});
        bus.pb_lr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("run_hold3", {3'b0, outs()}, {3'b0, O_RUN});
        end
        bus.pb_lr = 1'b0; tick();
        check("short_to_lap", {3'b0, outs()}, {3'b0, O_LAP});
        bus.pb_lr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lap_hold3", {3'b0, outs()}, {3'b0, O_LAP});
        end
        bus.pb_lr = 1'b0; tick();
        check("short_to_run", {3'b0, outs()}, {3'b0, O_RUN});

        // Single-cycle lr pulse counts as a short press
        bus.pb_lr = 1'b1; tick();
        check("pulse_rise", {3'b0, outs()}, {3'b0, O_RUN});
        bus.pb_lr = 1'b0; tick();
        check("pulse_to_lap", {3'b0, outs()}, {3'b0, O_LAP});

        // Long press in LAP: clr after the 4th high sample
        bus.pb_lr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lap_long_pre", {3'b0, outs()}, {3'b0, O_LAP});
        end
        tick();
        check("long_clr", {3'b0, outs()}, {3'b0, O_CLR});
        check("long_disarm", {7'b0, dut.armed}, 8'h00);
        tick();
        check("long_clr_once", {3'b0, outs()}, {3'b0, O_IDLE});
        bus.pb_lr = 1'b0; tick();
        check("long_release", {3'b0, outs()}, {3'b0, O_IDLE});

        // Simultaneous ss/lr rise in RUN -> STOP, not armed
        bus.pb_ss = 1'b1; tick();
        bus.pb_ss = 1'b0; tick();
        bus.pb_ss = 1'b1; bus.pb_lr = 1'b1; tick();
        check("run_both_stop", {3'b0, outs()}, {3'b0, O_STOP});
        check("run_both_unarmed", {7'b0, dut.armed}, 8'h00);
        bus.pb_ss = 1'b0; tick();
        bus.pb_lr = 1'b0; tick();
        check("stop_after_fall", {3'b0, outs()}, {3'b0, O_STOP});

        // Simultaneous rise in STOP -> RUN without clear; later fall ignored
        bus.pb_ss = 1'b1; bus.pb_lr = 1'b1; tick();
        check("stop_both_run", {3'b0, outs()}, {3'b0, O_RUN});
        bus.pb_ss = 1'b0; bus.pb_lr = 1'b0; tick();
        check("run_fall_ignored", {3'b0, outs()}, {3'b0, O_RUN});

        // Asynchronous reset mid-hold
        bus.pb_lr = 1'b1; tick(); tick();
        check("mid_hold_cnt", dut.hold_cnt, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {3'b0, outs()}, {3'b0, O_IDLE});
        bus.pb_lr = 1'b0;
        #1 rst_n = 1'b1;
        check("rst_hold_cnt", dut.hold_cnt, 8'd0);
        check("rst_armed", {7'b0, dut.armed}, 8'h00);
        tick();
        check("post_rst_idle", {3'b0, outs()}, {3'b0, O_IDLE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
